// File: rtl/urx_cmd_ctrl_pkg.sv
// Shared definitions for the UART command controller: FSM encoding, frame layout, counter width.
// Frame length depends on URX_CMD_CHK_EN (checksum byte present when defined).
package urx_cmd_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DH,
        ST_DL,
`ifdef URX_CMD_CHK_EN
        ST_CHK,
`endif
        ST_ISSUE
    } state_t;

    localparam logic [7:0] HDR_DEFAULT = 8'h55;

    localparam int OFS_HDR  = 0;
    localparam int OFS_CMD  = 1;
    localparam int OFS_ADDR = 2;
    localparam int OFS_DH   = 3;
    localparam int OFS_DL   = 4;
    localparam int OFS_CHK  = 5;

`ifdef URX_CMD_CHK_EN
    localparam int FRAME_LEN = OFS_CHK + 1;
`else
    localparam int FRAME_LEN = OFS_DL + 1;
`endif

    localparam int ERR_CNT_W = 8;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/urx_cmd_ctrl_if.sv
// Byte-receive and register-access bundle between the UART side, the controller and the register bank.
interface urx_cmd_ctrl_if;
    logic [7:0]  rx_data;
    logic        rx_vld;
    logic        cfg_req;
    logic        cfg_we;
    logic [7:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    logic        cfg_ack;

    modport slave (
        input  rx_data, rx_vld, cfg_ack,
        output cfg_req, cfg_we, cfg_addr, cfg_wdata
    );

    modport master (
        output rx_data, rx_vld, cfg_ack,
        input  cfg_req, cfg_we, cfg_addr, cfg_wdata
    );
endinterface

// File: rtl/urx_gap_timer.sv
// Inter-byte gap timer in microseconds; expired holds while the count sits at TIMEOUT_US.
module urx_gap_timer #(
    parameter int TIMEOUT_US = 1000
) (
    input  logic clk_sys,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic pluse_us,
    output logic expired
);
    localparam logic [15:0] LIMIT = 16'(TIMEOUT_US);

    logic [15:0] r_cnt;

    // Count stops at the limit so it cannot wrap while waiting for the FSM to react.
    always_ff @(posedge clk_sys) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (en && pluse_us && (r_cnt != LIMIT)) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign expired = en && (r_cnt == LIMIT);
endmodule

// File: rtl/urx_cmd_ctrl.sv
// Parses HDR/CMD/ADDR/DATA_H/DATA_L[/CHK] frames from the UART and issues one register access each.
// URX_CMD_CHK_EN defined adds the XOR checksum byte and its check.
module urx_cmd_ctrl
    import urx_cmd_ctrl_pkg::*;
#(
    parameter int         TIMEOUT_US = 1000,
    parameter logic [7:0] HDR        = HDR_DEFAULT
) (
    input  logic                 clk_sys,
    input  logic                 rst,
    input  logic                 pluse_us,
    urx_cmd_ctrl_if.slave        bus,
    output logic [ERR_CNT_W-1:0] err_cnt
);
    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_we;
    logic                  r_req;
    logic [7:0]            r_addr;
    logic [7:0]            r_dh;
    logic [7:0]            r_dl;
    logic [ERR_CNT_W-1:0]  r_err;
    logic                  w_err;
    logic                  w_issue;
    logic                  w_done;
    logic                  w_in_frame;
    logic                  w_tmr_clr;
    logic                  w_expired;

`ifdef URX_CMD_CHK_EN
    logic [7:0] w_chk;
    assign w_chk = {7'd0, r_we} ^ r_addr ^ r_dh ^ r_dl;
`endif

    assign w_in_frame = (r_state != ST_IDLE) && (r_state != ST_ISSUE);
    assign w_tmr_clr  = bus.rx_vld || !w_in_frame;

    urx_gap_timer #(
        .TIMEOUT_US (TIMEOUT_US)
    ) u_gap_timer (
        .clk_sys  (clk_sys),
        .rst      (rst),
        .clr      (w_tmr_clr),
        .en       (w_in_frame),
        .pluse_us (pluse_us),
        .expired  (w_expired)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_err       = 1'b0;
        w_issue     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: if (bus.rx_vld && (bus.rx_data == HDR)) w_state_nxt = ST_CMD;
            ST_CMD: begin
                if (bus.rx_vld) begin
                    if (|bus.rx_data[7:1]) begin
                        w_state_nxt = ST_IDLE;
                        w_err       = 1'b1;
                    end else begin
                        w_state_nxt = ST_ADDR;
                    end
                end
            end
            ST_ADDR: if (bus.rx_vld) w_state_nxt = ST_DH;
            ST_DH:   if (bus.rx_vld) w_state_nxt = ST_DL;
`ifdef URX_CMD_CHK_EN
            ST_DL:   if (bus.rx_vld) w_state_nxt = ST_CHK;
            ST_CHK: begin
                if (bus.rx_vld) begin
                    if (bus.rx_data == w_chk) begin
                        w_state_nxt = ST_ISSUE;
                        w_issue     = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_err       = 1'b1;
                    end
                end
            end
`else
            ST_DL: begin
                if (bus.rx_vld) begin
                    w_state_nxt = ST_ISSUE;
                    w_issue     = 1'b1;
                end
            end
`endif
            ST_ISSUE: begin
                // A byte arriving mid-request is dropped; the request itself carries on.
                if (bus.rx_vld) w_err = 1'b1;
                if (r_req && bus.cfg_ack) begin
                    w_state_nxt = ST_IDLE;
                    w_done      = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // A byte in the same cycle as the expiry wins over the timeout.
        if (w_in_frame && !bus.rx_vld && w_expired) begin
            w_state_nxt = ST_IDLE;
            w_err       = 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_req  <= 1'b0;
            r_we   <= 1'b0;
            r_addr <= '0;
            r_dh   <= '0;
            r_dl   <= '0;
            r_err  <= '0;
        end else begin
            if (w_err) r_err <= sat_inc(r_err);
            if (bus.rx_vld) begin
                case (r_state)
                    ST_CMD:  r_we   <= bus.rx_data[0];
                    ST_ADDR: r_addr <= bus.rx_data;
                    ST_DH:   r_dh   <= bus.rx_data;
                    ST_DL:   r_dl   <= bus.rx_data;
                    default: ;
                endcase
            end
            if (w_issue) begin
                r_req <= 1'b1;
            end else if (w_done) begin
                r_req <= 1'b0;
            end
        end
    end

    assign bus.cfg_req   = r_req;
    assign bus.cfg_we    = r_we;
    assign bus.cfg_addr  = r_addr;
    assign bus.cfg_wdata = {r_dh, r_dl};
    assign err_cnt       = r_err;
endmodule
